// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : sequential multiplier / divider
//
// Computes one operation at a time:
//   MPY : iterative shift-add, one multiplier bit per cycle (LSB first),
//         giving the full 2*WIDTH-bit product on {result_hi, result_lo}.
//   DIV : restoring division, one quotient bit per cycle (MSB first),
//         quotient on result_lo, remainder on result_hi.
//
// A divide by zero skips the iteration. It returns an all-ones quotient,
// returns the dividend as the remainder and raises div_zero.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   When it is defined, the operands are two's complement. The datapath
//   iterates on magnitudes, and an extra FIX state applies the sign
//   correction. When it is undefined, the operands are unsigned and FIX
//   does not exist.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   launch request, accepted only in IDLE
//   op        in   0 = MPY, 1 = DIV (sampled with start)
//   acc_in    in   multiplicand / dividend
//   br_in     in   multiplier / divisor
//   busy      out  high while iterating (CALC / FIX)
//   done      out  one-cycle completion pulse
//   result_hi out  product high half / remainder
//   result_lo out  product low half / quotient
//   div_zero  out  last DIV had a zero divisor
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] br_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isDiv_q, isDiv_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand (MPY) or divisor (DIV)
    logic [WIDTH-1:0] workHi_q, workHi_d;   // partial product high / partial remainder
    logic [WIDTH-1:0] workLo_q, workLo_d;   // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] resHi_q, resHi_d;
    logic [WIDTH-1:0] resLo_q, resLo_d;
    logic             divZero_q, divZero_d;
`ifdef MULDIV_SIGNED_EN
    logic             negA_q, negA_d;
    logic             negB_q, negB_d;
`endif

    logic [WIDTH-1:0] accMag, brMag;
    logic [WIDTH:0]   mpySum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic [WIDTH-1:0] stepHi, stepLo;

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] prodMag, prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;
    logic [WIDTH-1:0]   fixHi, fixLo;

    // The iteration runs on magnitudes. Negating the most negative value
    // wraps back to itself, which is still its correct unsigned magnitude.
    assign accMag = acc_in[WIDTH-1] ? (-acc_in) : acc_in;
    assign brMag  = br_in[WIDTH-1]  ? (-br_in)  : br_in;
`else
    assign accMag = acc_in;
    assign brMag  = br_in;
`endif

    // Shift-add adds the multiplicand into the high half. The carry out is
    // shifted back in from the top, so the product never overflows.
    assign mpySum   = {1'b0, workHi_q} + {1'b0, opnd_q};
    // Restoring step: shift the next dividend bit into the remainder and
    // try to subtract. A set MSB on the difference means "restore".
    assign divShift = {workHi_q, workLo_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opnd_q};

    // One iteration of either algorithm.
    always_comb begin
        stepHi = workHi_q;
        stepLo = workLo_q;
        if (isDiv_q) begin
            if (!divDiff[WIDTH]) begin
                stepHi = divDiff[WIDTH-1:0];
                stepLo = {workLo_q[WIDTH-2:0], 1'b1};
            end else begin
                stepHi = divShift[WIDTH-1:0];
                stepLo = {workLo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (workLo_q[0]) begin
                stepHi = mpySum[WIDTH:1];
                stepLo = {mpySum[0], workLo_q[WIDTH-1:1]};
            end else begin
                stepHi = {1'b0, workHi_q[WIDTH-1:1]};
                stepLo = {workHi_q[0], workLo_q[WIDTH-1:1]};
            end
        end
    end

`ifdef MULDIV_SIGNED_EN
    // Sign correction. The product sign is the XOR of the operand signs.
    // The quotient truncates toward zero. The remainder follows the dividend.
    always_comb begin
        prodMag = {workHi_q, workLo_q};
        prodFix = (negA_q ^ negB_q) ? (-prodMag) : prodMag;
        quoFix  = (negA_q ^ negB_q) ? (-workLo_q) : workLo_q;
        remFix  = negA_q ? (-workHi_q) : workHi_q;
        if (isDiv_q) begin
            fixHi = remFix;
            fixLo = quoFix;
        end else begin
            fixHi = prodFix[2*WIDTH-1:WIDTH];
            fixLo = prodFix[WIDTH-1:0];
        end
    end
`endif

    // Next-state and datapath control.
    // Results are written only on the transition into DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isDiv_d   = isDiv_q;
        opnd_d    = opnd_q;
        workHi_d  = workHi_q;
        workLo_d  = workLo_q;
        resHi_d   = resHi_q;
        resLo_d   = resLo_q;
        divZero_d = divZero_q;
`ifdef MULDIV_SIGNED_EN
        negA_d    = negA_q;
        negB_d    = negB_q;
`endif
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    isDiv_d   = op;
                    divZero_d = 1'b0;
                    cnt_d     = CW'(WIDTH - 1);
                    workHi_d  = '0;
`ifdef MULDIV_SIGNED_EN
                    negA_d    = acc_in[WIDTH-1];
                    negB_d    = br_in[WIDTH-1];
`endif
                    if (op) begin
                        opnd_d   = brMag;
                        workLo_d = accMag;
                        if (br_in == '0) begin
                            state_d   = DONE;
                            resHi_d   = acc_in;
                            resLo_d   = '1;
                            divZero_d = 1'b1;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        opnd_d   = accMag;
                        workLo_d = brMag;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                busy     = 1'b1;
                workHi_d = stepHi;
                workLo_d = stepLo;
                if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
                    resHi_d = stepHi;
                    resLo_d = stepLo;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
                resHi_d = fixHi;
                resLo_d = fixLo;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. All of them clear asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isDiv_q   <= 1'b0;
            opnd_q    <= '0;
            workHi_q  <= '0;
            workLo_q  <= '0;
            resHi_q   <= '0;
            resLo_q   <= '0;
            divZero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isDiv_q   <= isDiv_d;
            opnd_q    <= opnd_d;
            workHi_q  <= workHi_d;
            workLo_q  <= workLo_d;
            resHi_q   <= resHi_d;
            resLo_q   <= resLo_d;
            divZero_q <= divZero_d;
`ifdef MULDIV_SIGNED_EN
            negA_q    <= negA_d;
            negB_q    <= negB_d;
`endif
        end
    end

    assign result_hi = resHi_q;
    assign result_lo = resLo_q;
    assign div_zero  = divZero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : self-checking bench for muldiv_seq (WIDTH = 16)
//
// The bench has three parts:
//   - A table of fixed vectors with known results.
//   - Hand-written sequences: start pulsed while busy, and reset during CALC.
//   - Randomized operations checked against a plain-arithmetic reference.
//
// Latency is counted in clock edges. The start-accept edge counts as 1.
//
// Optional feature macro: MULDIV_SIGNED_EN (selects the signed tables and
// reference model).
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    localparam int W = 16;
`ifdef MULDIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif
    localparam int BUDGET = 3 * W + 10;
    localparam int NV = 8;

    typedef struct {
        string      name;
        logic       op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
        logic       expDz;
        int         expLat;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic       dz;
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] accIn = '0;
    logic [W-1:0] brIn = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] resultHi;
    logic [W-1:0] resultLo;
    logic         divZero;

    int testsRun = 0;
    int failures = 0;
    int doneCount = 0;
    logic [W-1:0] prevHi = '0;
    logic [W-1:0] prevLo = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .acc_in    (accIn),
        .br_in     (brIn),
        .busy      (busy),
        .done      (done),
        .result_hi (resultHi),
        .result_lo (resultLo),
        .div_zero  (divZero)
    );

    always #5 clk = ~clk;

    // Count done pulses on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (done) doneCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t refModel(input logic o, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, p, q, r;
        logic [63:0] bits;
`ifdef MULDIV_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        e.dz = 1'b0;
        e.lat = LAT;
        e.hi = '0;
        e.lo = '0;
        if (!o) begin
            p = sa * sb;
            bits = p;
            e.hi = bits[2*W-1:W];
            e.lo = bits[W-1:0];
        end else if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            bits = q;
            e.lo = bits[W-1:0];
            bits = r;
            e.hi = bits[W-1:0];
        end
        return e;
    endfunction

    // Launch one operation, then wait, within a bound, for its done cycle.
    // Returns when the FSM is back in IDLE.
    task automatic applyStimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo,
                                 output logic dz, output int lat, output logic busyAfter,
                                 output logic [W-1:0] heldHi, output logic [W-1:0] heldLo);
        @(negedge clk);
        start = 1'b1;
        op = o;
        accIn = a;
        brIn = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyAfter = busy;
        heldHi = resultHi;
        heldLo = resultLo;
        lat = 1;
        while (!done && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        hi = resultHi;
        lo = resultLo;
        dz = divZero;
        @(posedge clk);
        #1;
    endtask

    task automatic runCheck(input string name, input logic o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] expHi,
                            input logic [W-1:0] expLo, input logic expDz, input int expLat);
        logic [W-1:0] hi, lo, heldHi, heldLo;
        logic dz, busyAfter;
        int lat, dc0;
        dc0 = doneCount;
        applyStimulus(o, a, b, hi, lo, dz, lat, busyAfter, heldHi, heldLo);
        checkOutput({name, " result_hi"}, hi, expHi);
        checkOutput({name, " result_lo"}, lo, expLo);
        checkOutput({name, " div_zero"}, dz, expDz);
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " busy after accept"}, busyAfter, (expLat > 1));
        if (expLat > 1) begin
            checkOutput({name, " result_hi held"}, heldHi, prevHi);
            checkOutput({name, " result_lo held"}, heldLo, prevLo);
        end
        checkOutput({name, " done pulses"}, doneCount - dc0, 1);
        prevHi = expHi;
        prevLo = expLo;
    endtask

    initial begin
        vec_t vecs[NV];
        exp_t e;
        logic [W-1:0] ra, rb;
        logic ro;
        int lat, dc0;

`ifdef MULDIV_SIGNED_EN
        vecs[0] = '{"mpy -6x7",       1'b0, 16'hFFFA, 16'h0007, 16'hFFFF, 16'hFFD6, 1'b0, 18};
        vecs[1] = '{"div -7/2",       1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 18};
        vecs[2] = '{"div min/-1",     1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18};
        vecs[3] = '{"div 100/7",      1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 18};
        vecs[4] = '{"div 100/0",      1'b1, 16'd100,  16'd0,    16'd100,  16'hFFFF, 1'b1, 1};
        vecs[5] = '{"mpy -1x-1",      1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 18};
        vecs[6] = '{"div 7/-2",       1'b1, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 18};
        vecs[7] = '{"mpy min x min",  1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 18};
`else
        vecs[0] = '{"mpy 3x5",        1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17};
        vecs[1] = '{"mpy FFFFxFFFF",  1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
        vecs[2] = '{"mpy 0x1234",     1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[3] = '{"mpy 8000x2",     1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17};
        vecs[4] = '{"div 100/7",      1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 17};
        vecs[5] = '{"div 100/0",      1'b1, 16'd100,  16'd0,    16'd100,  16'hFFFF, 1'b1, 1};
        vecs[6] = '{"div 5/9",        1'b1, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0, 17};
        vecs[7] = '{"div FFFF/1",     1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
`endif

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset result_hi", resultHi, '0);
        checkOutput("reset result_lo", resultLo, '0);
        checkOutput("reset div_zero", divZero, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            runCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].expHi, vecs[i].expLo, vecs[i].expDz, vecs[i].expLat);
        end

        // A start pulsed 5 cycles into MPY 3x5 must be ignored.
        dc0 = doneCount;
        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        accIn = 16'd3;
        brIn = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        start = 1'b1;
        op = 1'b1;
        accIn = 16'd100;
        brIn = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (!done && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        checkOutput("ignored start latency", lat, LAT);
        checkOutput("ignored start result_hi", resultHi, 16'h0000);
        checkOutput("ignored start result_lo", resultLo, 16'h000F);
        checkOutput("ignored start div_zero", divZero, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ignored start done pulses", doneCount - dc0, 1);
        prevHi = 16'h0000;
        prevLo = 16'h000F;

        // Reset during CALC aborts the operation without a done pulse.
        dc0 = doneCount;
        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        accIn = 16'h1234;
        brIn = 16'h0011;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid-calc reset busy", busy, 1'b0);
        checkOutput("mid-calc reset result_hi", resultHi, '0);
        checkOutput("mid-calc reset result_lo", resultLo, '0);
        checkOutput("mid-calc reset div_zero", divZero, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        checkOutput("mid-calc reset done pulses", doneCount - dc0, 0);
        prevHi = '0;
        prevLo = '0;
        runCheck("mpy 2x2 after reset", 1'b0, 16'd2, 16'd2, 16'd0, 16'd4, 1'b0, LAT);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = '0;
            ro = 1'($urandom_range(0, 1));
            e = refModel(ro, ra, rb);
            runCheck($sformatf("rand%0d op%0d %0h,%0h", i, ro, ra, rb), ro, ra, rb,
                     e.hi, e.lo, e.dz, e.lat);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width; the block SHALL support WIDTH of 8 to 32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  launch request, sampled on clk.
REQ-005 op  input  1  operation select: 0 = MPY, 1 = DIV; sampled with start.
REQ-006 acc_in  input  WIDTH  multiplicand / dividend (ACC value).
REQ-007 br_in  input  WIDTH  multiplier / divisor (BR value).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result_hi  output  WIDTH  MPY high product half (to MR) / DIV remainder.
REQ-011 result_lo  output  WIDTH  MPY low product half / DIV quotient.
REQ-012 div_zero  output  1  last DIV had a zero divisor; valid from done until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE; FIX exists only when MULDIV_SIGNED_EN is defined.
REQ-014 In IDLE, start=1 SHALL be accepted: acc_in, br_in and op are captured and the FSM enters CALC next cycle.
REQ-015 Acceptance of start SHALL clear div_zero and busy SHALL be high from the cycle after acceptance until done is asserted.
REQ-016 start while busy or done is high SHALL be ignored, with no effect on operands, results or state.
REQ-017 CALC SHALL run exactly WIDTH cycles under a down-counter loaded with WIDTH-1 on acceptance; the FSM SHALL exit CALC when the counter reads 0.
REQ-018 MPY SHALL use iterative shift-add, one multiplier bit per cycle, LSB first, with a 2*WIDTH-bit product and no overflow.
REQ-019 DIV SHALL use restoring division, one quotient bit per cycle, MSB first.
REQ-020 DIV with br_in=0 SHALL skip CALC and enter DONE next cycle with result_lo = all ones, result_hi = dividend and div_zero=1.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then the FSM SHALL return to IDLE.
REQ-022 Latency from the start-accept edge to the done cycle SHALL be WIDTH+1 cycles (WIDTH+2 with FIX), and 1 cycle for divide-by-zero.
REQ-023 result_hi and result_lo SHALL update only on entry to DONE and hold until the next DONE.
REQ-024 Accept-to-accept throughput SHALL be at most one operation per WIDTH+2 cycles, because start is accepted again only in IDLE.

Reset
REQ-025 When rst=0, all outputs, the counter and the operand registers SHALL clear to 0 asynchronously and the FSM SHALL enter IDLE.
REQ-026 Reset during CALC or FIX SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-027 With MULDIV_SIGNED_EN defined, operands SHALL be two's complement: CALC works on magnitudes and FIX applies sign correction in one cycle.
REQ-028 Under MULDIV_SIGNED_EN, the product sign SHALL be the XOR of the operand signs, the quotient SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-029 Under MULDIV_SIGNED_EN, DIV of the most negative value by -1 SHALL return result_lo = most negative value and result_hi = 0.
REQ-030 Without MULDIV_SIGNED_EN, operands SHALL be unsigned, the FIX state SHALL be absent and latency SHALL be WIDTH+1.

Verification
REQ-031 WIDTH=16, unsigned: MPY 3 x 5 -> done 17 cycles after accept, result_hi=0x0000, result_lo=0x000F; MPY 0xFFFF x 0xFFFF -> result_hi=0xFFFE, result_lo=0x0001.
REQ-032 DIV 100 / 7 -> result_lo=14, result_hi=2, div_zero=0; DIV 100 / 0 -> done 1 cycle after accept, result_lo=0xFFFF, result_hi=100, div_zero=1.
REQ-033 start pulsed again 5 cycles after acceptance with new operands -> ignored; results match the first operation and exactly one done pulse occurs.
REQ-034 rst low at cycle 8 of CALC -> busy=0 and results 0 immediately, no done pulse; the next MPY 2 x 2 returns 4.
REQ-035 With MULDIV_SIGNED_EN: MPY -6 x 7 -> {result_hi,result_lo}=0xFFFF_FFD6, latency 18; DIV -7 / 2 -> result_lo=0xFFFD, result_hi=0xFFFF; DIV 0x8000 / 0xFFFF -> result_lo=0x8000, result_hi=0.
